// File: rtl/sha_sched_pkg.sv
// Shared types and constants for the SHA job scheduler.
// Optional watchdog is enabled by defining SHA_SCHED_TIMEOUT_EN.
package sha_sched_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned ID_W    = 3;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_ACK,
    WAIT_DONE,
    COMPLETE
  } sched_state_t;

  typedef struct packed {
    logic [15:0]     msg_addr;
    logic [15:0]     out_addr;
    logic [ID_W-1:0] id;
  } job_desc_t;

  function automatic logic [MAX_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    return MAX_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/sha_job_scheduler_rr_arbiter.sv
// Combinational round-robin selector: the search starts one past the last
// granted index and wraps modulo NUM_REQ; the first active request wins.
module rr_arbiter
  import sha_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  int unsigned cand;
  logic        found;

  // Walk candidates in rotating priority order, keep the first hit
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(last_grant) + i) % NUM_REQ;
      if (!found && ((req >> cand) & NUM_REQ'(1)) != '0) begin
        found     = 1'b1;
        grant     = NUM_REQ'(1) << cand;
        grant_idx = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sha_job_scheduler.sv
// Shares one simplified_sha256 core among NUM_REQ requesters, one job at a
// time, with round-robin fairness. Define SHA_SCHED_TIMEOUT_EN to add a
// watchdog that aborts a job after TIMEOUT_CYCLES and reports cmpl_err.
module sha_job_scheduler
  import sha_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*16-1:0]   req_msg_addr,
  input  logic [NUM_REQ*16-1:0]   req_out_addr,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      cmpl_valid,
  output logic                    cmpl_err,
  output logic                    core_start,
  output logic [15:0]             core_message_addr,
  output logic [15:0]             core_output_addr,
  input  logic                    core_done,
  output logic                    busy,
  output logic [2:0]              grant_id
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("sha_job_scheduler: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  sched_state_t        state;
  job_desc_t           job;
  logic [ID_W-1:0]     last_grant;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [ID_W-1:0]     arb_idx;
  logic [15:0]         sel_msg;
  logic [15:0]         sel_out;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  // Pick the winning requester's address pair
  always_comb begin
    sel_msg = '0;
    sel_out = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_msg = req_msg_addr[i*16 +: 16];
        sel_out = req_out_addr[i*16 +: 16];
      end
    end
  end

  // Job descriptor drives the core and owner outputs for the whole job
  assign core_message_addr = job.msg_addr;
  assign core_output_addr  = job.out_addr;
  assign grant_id          = job.id;
  assign busy              = (state != IDLE);

`ifdef SHA_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;
  logic            wd_hit;
  // Hit on the cycle the counter would reach TIMEOUT_CYCLES
  assign wd_hit = (wd == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign cmpl_err = 1'b0;
`endif

  // Scheduler FSM with registered pulse outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      job        <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      req_ready  <= '0;
      cmpl_valid <= '0;
      core_start <= 1'b0;
`ifdef SHA_SCHED_TIMEOUT_EN
      wd         <= '0;
      cmpl_err   <= 1'b0;
`endif
    end else begin
      req_ready  <= '0;
      cmpl_valid <= '0;
      core_start <= 1'b0;
`ifdef SHA_SCHED_TIMEOUT_EN
      cmpl_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (core_done && (req_valid != '0)) begin
            job        <= '{msg_addr: sel_msg, out_addr: sel_out, id: arb_idx};
            last_grant <= arb_idx;
            req_ready  <= arb_grant;
            core_start <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
`ifdef SHA_SCHED_TIMEOUT_EN
          wd    <= '0;
`endif
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
`ifdef SHA_SCHED_TIMEOUT_EN
          wd <= wd + 1'b1;
`endif
          if (!core_done) begin
            state <= WAIT_DONE;
          end
`ifdef SHA_SCHED_TIMEOUT_EN
          else if (wd_hit) begin
            state      <= COMPLETE;
            cmpl_valid <= NUM_REQ'(id_to_onehot(job.id));
            cmpl_err   <= 1'b1;
          end
`endif
        end
        WAIT_DONE: begin
`ifdef SHA_SCHED_TIMEOUT_EN
          wd <= wd + 1'b1;
`endif
          if (core_done) begin
            state      <= COMPLETE;
            cmpl_valid <= NUM_REQ'(id_to_onehot(job.id));
          end
`ifdef SHA_SCHED_TIMEOUT_EN
          else if (wd_hit) begin
            state      <= COMPLETE;
            cmpl_valid <= NUM_REQ'(id_to_onehot(job.id));
            cmpl_err   <= 1'b1;
          end
`endif
        end
        COMPLETE: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_job_scheduler.sv
// Directed bench for sha_job_scheduler with a simple core model.
// Timeout sequence is active when SHA_SCHED_TIMEOUT_EN is defined.
module tb_sha_job_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [63:0] req_msg_addr;
  logic [63:0] req_out_addr;
  logic [3:0]  req_ready;
  logic [3:0]  cmpl_valid;
  logic        cmpl_err;
  logic        core_start;
  logic [15:0] core_message_addr;
  logic [15:0] core_output_addr;
  logic        core_done;
  logic        busy;
  logic [2:0]  grant_id;

  int checks = 0;
  int errors = 0;

  logic [15:0] msg_tab [4] = '{16'h1000, 16'h1100, 16'h0100, 16'h1300};
  logic [15:0] out_tab [4] = '{16'h2000, 16'h2100, 16'h0200, 16'h2300};

  assign req_msg_addr = {msg_tab[3], msg_tab[2], msg_tab[1], msg_tab[0]};
  assign req_out_addr = {out_tab[3], out_tab[2], out_tab[1], out_tab[0]};

  always #5 clk = ~clk;

  sha_job_scheduler #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req_valid         (req_valid),
    .req_msg_addr      (req_msg_addr),
    .req_out_addr      (req_out_addr),
    .req_ready         (req_ready),
    .cmpl_valid        (cmpl_valid),
    .cmpl_err          (cmpl_err),
    .core_start        (core_start),
    .core_message_addr (core_message_addr),
    .core_output_addr  (core_output_addr),
    .core_done         (core_done),
    .busy              (busy),
    .grant_id          (grant_id)
  );

  // Core model: done drops the cycle after start, returns lat+1 cycles later
  bit          force_en  = 1'b0;
  logic        force_val = 1'b1;
  logic        done_m    = 1'b1;
  int unsigned lat       = 2;
  int unsigned cnt       = 0;

  always @(posedge clk) begin
    if (core_start) begin
      done_m <= 1'b0;
      cnt    <= lat;
    end else if (!done_m) begin
      if (cnt == 0) done_m <= 1'b1;
      else          cnt    <= cnt - 1;
    end
  end

  assign core_done = force_en ? force_val : done_m;

  // Start spacing / single-job-in-flight monitor and completion counter
  int unsigned gap = 1000;
  bit          inflight = 1'b0;
  int          cmpl_cnt = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      inflight = 1'b0;
    end else begin
      gap++;
      if (core_start) begin
        checks++;
        if (gap < 4 || inflight) begin
          errors++;
          $display("FAIL start_spacing: gap %0d inflight %0d, required gap>=4 inflight 0", gap, inflight);
        end
        gap      = 0;
        inflight = 1'b1;
      end
      if (cmpl_valid != '0) begin
        cmpl_cnt++;
        inflight = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait expired", name);
  endtask

  task automatic wait_ready(input int unsigned budget, output bit got);
    got = 1'b0;
    for (int unsigned i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1'b1;
    end
    if (!got) timeout_fail("wait_ready");
  endtask

  task automatic wait_cmpl(input int unsigned budget, output bit got);
    got = 1'b0;
    for (int unsigned i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (cmpl_valid != '0) got = 1'b1;
    end
    if (!got) timeout_fail("wait_cmpl");
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    check("rst_flags", 32'({req_ready, cmpl_valid, cmpl_err, core_start, busy, grant_id}), 0);
    check("rst_addrs", {core_message_addr, core_output_addr}, 0);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  req;
    int unsigned lat;
    logic [2:0]  exp_id;
  } vec_t;

  vec_t vecs [10];

  task automatic run_vec(input vec_t v);
    logic [3:0] exp_oh;
    bit         got;
    exp_oh = 4'b0001 << v.exp_id;
    lat    = v.lat;
    @(negedge clk);
    req_valid = v.req;
    wait_ready(20, got);
    check("req_ready", 32'(req_ready), 32'(exp_oh));
    check("grant_id", 32'(grant_id), 32'(v.exp_id));
    check("start_on", 32'(core_start), 1);
    check("launch_msg", 32'(core_message_addr), 32'(msg_tab[v.exp_id[1:0]]));
    check("launch_out", 32'(core_output_addr), 32'(out_tab[v.exp_id[1:0]]));
    req_valid = '0;
    @(negedge clk);
    check("start_width", 32'(core_start), 0);
    wait_cmpl(v.lat + 40, got);
    check("cmpl_valid", 32'(cmpl_valid), 32'(exp_oh));
    check("cmpl_err", 32'(cmpl_err), 0);
    check("held_addr", {core_message_addr, core_output_addr},
          {msg_tab[v.exp_id[1:0]], out_tab[v.exp_id[1:0]]});
    @(negedge clk);
    check("cmpl_width_idle", 32'({cmpl_valid, busy}), 0);
  endtask

  initial begin
    bit got;
    bit seen;
    int cmpl_before;
    int n;

    vecs[0] = '{req: 4'b0100, lat: 299, exp_id: 3'd2};
    vecs[1] = '{req: 4'b1111, lat: 0,   exp_id: 3'd3};
    vecs[2] = '{req: 4'b1111, lat: 1,   exp_id: 3'd0};
    vecs[3] = '{req: 4'b0110, lat: 2,   exp_id: 3'd1};
    vecs[4] = '{req: 4'b0001, lat: 3,   exp_id: 3'd0};
    vecs[5] = '{req: 4'b1010, lat: 4,   exp_id: 3'd1};
    vecs[6] = '{req: 4'b1010, lat: 5,   exp_id: 3'd3};
    vecs[7] = '{req: 4'b0100, lat: 0,   exp_id: 3'd2};
    vecs[8] = '{req: 4'b1001, lat: 1,   exp_id: 3'd3};
    vecs[9] = '{req: 4'b1001, lat: 2,   exp_id: 3'd0};

    reset_n   = 1'b0;
    req_valid = '0;
    do_reset();

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // All four requesters continuously: order 0,1,2,3,0 from reset
    do_reset();
    lat       = 2;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ready(20, got);
      check("rr_continuous", 32'(grant_id), 32'(k % 4));
      req_valid = req_valid & ~req_ready;
      wait_cmpl(40, got);
      check("rr_cont_cmpl", 32'(cmpl_valid), 32'(4'b0001 << (k % 4)));
      if (k == 4) req_valid = '0;
      else        req_valid = req_valid | cmpl_valid;
    end

    // Requester 1 reasserts on its completion while 3 is pending
    @(negedge clk);
    req_valid = 4'b0010;
    wait_ready(20, got);
    check("reassert_first", 32'(grant_id), 1);
    req_valid = 4'b1000;
    wait_cmpl(40, got);
    req_valid = req_valid | cmpl_valid;
    wait_ready(20, got);
    check("reassert_pending_wins", 32'(grant_id), 3);
    req_valid = req_valid & ~req_ready;
    wait_cmpl(40, got);
    wait_ready(20, got);
    check("reassert_then_one", 32'(grant_id), 1);
    req_valid = '0;
    wait_cmpl(40, got);

    // core_done low in IDLE blocks any grant
    @(negedge clk);
    force_en  = 1'b1;
    force_val = 1'b0;
    req_valid = 4'b0001;
    seen      = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (req_ready != '0 || core_start) seen = 1'b1;
    end
    check("done_low_hold", 32'(seen), 0);
    force_en = 1'b0;
    wait_ready(10, got);
    check("done_low_release", 32'(grant_id), 0);
    req_valid = '0;
    wait_cmpl(40, got);

    // Reset during WAIT_DONE abandons the job
    do_reset();
    lat       = 50;
    req_valid = 4'b0100;
    wait_ready(20, got);
    check("midrst_grant", 32'(grant_id), 2);
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("midrst_in_wait_done", 32'({busy, core_done}), 32'(2'b10));
    cmpl_before = cmpl_cnt;
    reset_n     = 1'b0;
    @(negedge clk);
    check("midrst_flags_a", 32'({req_ready, cmpl_valid, cmpl_err, core_start, busy, grant_id}), 0);
    @(negedge clk);
    check("midrst_flags_b", 32'({req_ready, cmpl_valid, cmpl_err, core_start, busy, grant_id}), 0);
    check("midrst_addrs", {core_message_addr, core_output_addr}, 0);
    reset_n = 1'b1;
    repeat (80) @(negedge clk);
    check("midrst_no_cmpl", cmpl_cnt, cmpl_before);
    lat       = 3;
    req_valid = 4'b1111;
    wait_ready(100, got);
    check("midrst_next_grant", 32'(grant_id), 0);
    req_valid = '0;
    wait_cmpl(40, got);

`ifdef SHA_SCHED_TIMEOUT_EN
    // Core never acknowledges: watchdog completes with error at LAUNCH+17
    @(negedge clk);
    force_en  = 1'b1;
    force_val = 1'b1;
    req_valid = 4'b0010;
    wait_ready(20, got);
    req_valid = '0;
    n   = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      n++;
      if (cmpl_valid != '0) got = 1'b1;
    end
    if (!got) timeout_fail("wd_wait");
    check("wd_latency", n, 17);
    check("wd_cmpl_valid", 32'(cmpl_valid), 32'(4'b0010));
    check("wd_cmpl_err", 32'(cmpl_err), 1);
    force_val = 1'b0;
    req_valid = 4'b0100;
    seen      = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (req_ready != '0) seen = 1'b1;
    end
    check("wd_hold_idle", 32'(seen), 0);
    force_val = 1'b1;
    wait_ready(10, got);
    check("wd_resume_grant", 32'(grant_id), 2);
    req_valid = '0;
    force_en  = 1'b0;
    wait_cmpl(60, got);
    check("wd_resume_err", 32'(cmpl_err), 0);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
